// File: rtl/ddr3_ram_arbiter.sv
// ddr3_ram_arbiter
// Shares the DDR3 core's single 128-bit request interface between two
// requesters. Arbitration is round-robin. A grant is held until the core
// accepts it. Request IDs are tagged with the source port in bit 15 so
// that responses can be routed back. Each port may have at most
// MAX_OUTSTANDING requests accepted but not yet acked.
module ddr3_ram_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  in_wr_i,
    input  logic [1:0]   in_rd_i,
    input  logic [31:0]  in_req_id_i,
    input  logic [63:0]  in_addr_i,
    input  logic [255:0] in_write_data_i,
    output logic [1:0]   in_accept_o,
    output logic [1:0]   in_ack_o,
    output logic         in_error_o,
    output logic [127:0] in_read_data_o,
    output logic [15:0]  in_resp_id_o,
    output logic [15:0]  ram_wr_o,
    output logic         ram_rd_o,
    output logic [15:0]  ram_req_id_o,
    output logic [31:0]  ram_addr_o,
    output logic [127:0] ram_write_data_o,
    input  logic         ram_accept_i,
    input  logic         ram_ack_i,
    input  logic         ram_error_i,
    input  logic [127:0] ram_read_data_i,
    input  logic [15:0]  ram_resp_id_i
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] cnt0_q;
    logic [CW-1:0] cnt1_q;
    logic          last_q;
    logic          hold_q;
    logic          hold_port_q;

    logic [1:0]    req;
    logic [1:0]    elig;
    logic          grant_valid;
    logic          grant;

    // Bit 15 of each incoming ID is replaced by the port tag, so it is never read.
    logic          unused_id_bits;
    assign unused_id_bits = &{1'b0, in_req_id_i[15], in_req_id_i[31]};

    // Work out which ports are requesting and which are still under their outstanding limit.
    always_comb begin
        req[0]  = in_rd_i[0] | (|in_wr_i[15:0]);
        req[1]  = in_rd_i[1] | (|in_wr_i[31:16]);
        elig[0] = req[0] & (cnt0_q < CW'(MAX_OUTSTANDING));
        elig[1] = req[1] & (cnt1_q < CW'(MAX_OUTSTANDING));
    end

    // Pick the winner: a held grant wins first, then round-robin between eligible ports.
    always_comb begin
        grant_valid = 1'b0;
        grant       = 1'b0;
        if (hold_q && req[hold_port_q]) begin
            grant_valid = 1'b1;
            grant       = hold_port_q;
        end else if (&elig) begin
            grant_valid = 1'b1;
            grant       = ~last_q;
        end else if (elig[0]) begin
            grant_valid = 1'b1;
            grant       = 1'b0;
        end else if (elig[1]) begin
            grant_valid = 1'b1;
            grant       = 1'b1;
        end
    end

    // Steer the granted port's request fields to the core; strobes stay low during reset.
    always_comb begin
        ram_wr_o         = '0;
        ram_rd_o         = 1'b0;
        ram_req_id_o     = '0;
        ram_addr_o       = '0;
        ram_write_data_o = '0;
        if (grant_valid) begin
            if (grant) begin
                ram_wr_o         = in_wr_i[31:16];
                ram_rd_o         = in_rd_i[1];
                ram_req_id_o     = {1'b1, in_req_id_i[30:16]};
                ram_addr_o       = in_addr_i[63:32];
                ram_write_data_o = in_write_data_i[255:128];
            end else begin
                ram_wr_o         = in_wr_i[15:0];
                ram_rd_o         = in_rd_i[0];
                ram_req_id_o     = {1'b0, in_req_id_i[14:0]};
                ram_addr_o       = in_addr_i[31:0];
                ram_write_data_o = in_write_data_i[127:0];
            end
        end
        if (rst_i) begin
            ram_wr_o = '0;
            ram_rd_o = 1'b0;
        end
    end

    // Return the core's accept to the granted port, and route the response by its port tag.
    always_comb begin
        in_accept_o = 2'b00;
        in_ack_o    = 2'b00;
        if (ram_accept_i && grant_valid && !rst_i) begin
            in_accept_o = grant ? 2'b10 : 2'b01;
        end
        if (ram_ack_i && !rst_i) begin
            in_ack_o = ram_resp_id_i[15] ? 2'b10 : 2'b01;
        end
        in_resp_id_o   = {1'b0, ram_resp_id_i[14:0]};
        in_error_o     = ram_error_i;
        in_read_data_o = ram_read_data_i;
    end

    // Hold an unaccepted grant, and remember the last accepted port for round-robin.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q      <= 1'b1;
            hold_q      <= 1'b0;
            hold_port_q <= 1'b0;
        end else if (grant_valid) begin
            if (ram_accept_i) begin
                hold_q <= 1'b0;
                last_q <= grant;
            end else begin
                hold_q      <= 1'b1;
                hold_port_q <= grant;
            end
        end else begin
            hold_q <= 1'b0;
        end
    end

    // Track outstanding requests per port; a same-cycle accept and ack cancel, and an ack at zero is ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (in_accept_o[0] && !in_ack_o[0]) begin
                cnt0_q <= cnt0_q + CW'(1);
            end else if (in_ack_o[0] && !in_accept_o[0] && cnt0_q != '0) begin
                cnt0_q <= cnt0_q - CW'(1);
            end
            if (in_accept_o[1] && !in_ack_o[1]) begin
                cnt1_q <= cnt1_q + CW'(1);
            end else if (in_ack_o[1] && !in_accept_o[1] && cnt1_q != '0) begin
                cnt1_q <= cnt1_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ddr3_ram_arbiter.sv
// Testbench for ddr3_ram_arbiter: directed steps driven on the falling edge,
// with expected core request IDs queued when a request is driven and popped
// whenever the arbiter accepts one.
module tb_ddr3_ram_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  in_wr;
    logic [1:0]   in_rd;
    logic [31:0]  in_req_id;
    logic [63:0]  in_addr;
    logic [255:0] in_wdata;
    logic [1:0]   in_accept_o;
    logic [1:0]   in_ack_o;
    logic         in_error_o;
    logic [127:0] in_read_data_o;
    logic [15:0]  in_resp_id_o;
    logic [15:0]  ram_wr_o;
    logic         ram_rd_o;
    logic [15:0]  ram_req_id_o;
    logic [31:0]  ram_addr_o;
    logic [127:0] ram_write_data_o;
    logic         ram_accept;
    logic         ram_ack;
    logic         ram_error;
    logic [127:0] ram_rdata;
    logic [15:0]  ram_resp_id;

    int compared   = 0;
    int mismatched = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_id;
    logic [15:0] prev_id;

    always #5 clk = ~clk;

    ddr3_ram_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_wr_i          (in_wr),
        .in_rd_i          (in_rd),
        .in_req_id_i      (in_req_id),
        .in_addr_i        (in_addr),
        .in_write_data_i  (in_wdata),
        .in_accept_o      (in_accept_o),
        .in_ack_o         (in_ack_o),
        .in_error_o       (in_error_o),
        .in_read_data_o   (in_read_data_o),
        .in_resp_id_o     (in_resp_id_o),
        .ram_wr_o         (ram_wr_o),
        .ram_rd_o         (ram_rd_o),
        .ram_req_id_o     (ram_req_id_o),
        .ram_addr_o       (ram_addr_o),
        .ram_write_data_o (ram_write_data_o),
        .ram_accept_i     (ram_accept),
        .ram_ack_i        (ram_ack),
        .ram_error_i      (ram_error),
        .ram_read_data_i  (ram_rdata),
        .ram_resp_id_i    (ram_resp_id)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] rd, input logic [15:0] wr0, input logic [15:0] wr1,
                                 input logic [15:0] id0, input logic [15:0] id1, input logic acc);
        in_rd      = rd;
        in_wr      = {wr1, wr0};
        in_req_id  = {id1, id0};
        ram_accept = acc;
    endtask

    task automatic applyResponse(input logic ack, input logic err, input logic [15:0] id, input logic [127:0] data);
        ram_ack     = ack;
        ram_error   = err;
        ram_resp_id = id;
        ram_rdata   = data;
    endtask

    task automatic expectRequest(input logic [15:0] id);
        exp_q.push_back(id);
    endtask

    // Pop the oldest expected request whenever the arbiter accepts one.
    task automatic checkScoreboard();
        logic [15:0] e;
        if (in_accept_o != 2'b00) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb unexpected accept", 128'(in_accept_o), 128'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb req_id", 128'(ram_req_id_o), 128'(e));
                checkOutput("sb port", 128'(in_accept_o), e[15] ? 128'd2 : 128'd1);
            end
        end
    endtask

    initial begin
        in_addr  = '0;
        in_wdata = '0;
        applyStimulus(2'b01, 16'h0, 16'h0, 16'h0012, 16'h0, 1'b1);
        applyResponse(1'b1, 1'b0, 16'h0000, 128'h0);

        // Reset: strobes forced low even with a request and ack present
        @(negedge clk); #1;
        checkOutput("reset accept", 128'(in_accept_o), 128'd0);
        checkOutput("reset ram_rd", 128'(ram_rd_o), 128'd0);
        checkOutput("reset ram_wr", 128'(ram_wr_o), 128'd0);
        checkOutput("reset ack", 128'(in_ack_o), 128'd0);

        // Single port0 read accepted in the same cycle, then acked
        @(negedge clk);
        rst     = 1'b0;
        in_addr = {32'h0, 32'h100};
        applyStimulus(2'b01, 16'h0, 16'h0, 16'h0012, 16'h0, 1'b1);
        applyResponse(1'b0, 1'b0, 16'h0, 128'h0);
        expectRequest(16'h0012);
        #1;
        checkOutput("t1 ram_rd", 128'(ram_rd_o), 128'd1);
        checkOutput("t1 ram_addr", 128'(ram_addr_o), 128'h100);
        checkOutput("t1 accept", 128'(in_accept_o), 128'd1);
        checkScoreboard();
        @(negedge clk);
        applyStimulus(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        applyResponse(1'b1, 1'b0, 16'h0012, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1122_3344);
        #1;
        checkOutput("t1 ack", 128'(in_ack_o), 128'd1);
        checkOutput("t1 resp_id", 128'(in_resp_id_o), 128'h0012);
        checkOutput("t1 rdata", in_read_data_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1122_3344);
        checkOutput("t1 idle ram_rd", 128'(ram_rd_o), 128'd0);

        // Round-robin after a fresh reset: 0,1,0,1,0 with prompt acks
        @(negedge clk);
        applyResponse(1'b0, 1'b0, 16'h0, 128'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        prev_id = 16'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            applyStimulus(2'b11, 16'h0, 16'h0, 16'h8001, 16'h0002, 1'b1);
            if (i == 0) applyResponse(1'b0, 1'b0, 16'h0, 128'h0);
            else        applyResponse(1'b1, 1'b0, prev_id, 128'(i));
            exp_id = (i % 2 == 0) ? 16'h0001 : 16'h8002;
            expectRequest(exp_id);
            #1;
            checkOutput("rr grant bit", 128'(ram_req_id_o[15]), 128'(exp_id[15]));
            checkScoreboard();
            if (i > 0) checkOutput("rr ack", 128'(in_ack_o), prev_id[15] ? 128'd2 : 128'd1);
            prev_id = exp_id;
        end
        @(negedge clk);
        applyStimulus(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        applyResponse(1'b1, 1'b0, prev_id, 128'h0);
        #1;
        checkOutput("rr last ack", 128'(in_ack_o), 128'd1);

        // Hold: port0 write stalls 3 cycles while port1 raises a read
        in_addr  = {32'h0, 32'h200};
        in_wdata = {128'h0, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyResponse(1'b0, 1'b0, 16'h0, 128'h0);
            applyStimulus((i == 0) ? 2'b00 : 2'b10, 16'h000F, 16'h0, 16'h0033, 16'h0044, (i == 3));
            if (i == 3) expectRequest(16'h0033);
            #1;
            checkOutput("hold ram_wr", 128'(ram_wr_o), 128'h000F);
            checkOutput("hold ram_addr", 128'(ram_addr_o), 128'h200);
            checkOutput("hold wdata", ram_write_data_o, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0);
            checkOutput("hold accept", 128'(in_accept_o), (i == 3) ? 128'd1 : 128'd0);
            checkScoreboard();
        end
        @(negedge clk);
        applyStimulus(2'b10, 16'h0, 16'h0, 16'h0033, 16'h0044, 1'b1);
        expectRequest(16'h8044);
        #1;
        checkOutput("after hold accept", 128'(in_accept_o), 128'd2);
        checkOutput("after hold ram_rd", 128'(ram_rd_o), 128'd1);
        checkOutput("after hold ram_wr", 128'(ram_wr_o), 128'd0);
        checkScoreboard();
        @(negedge clk);
        applyStimulus(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        applyResponse(1'b1, 1'b0, 16'h0033, 128'h0);
        #1;
        checkOutput("drain ack0", 128'(in_ack_o), 128'd1);
        @(negedge clk);
        applyResponse(1'b1, 1'b0, 16'h8044, 128'h0);
        #1;
        checkOutput("drain ack1", 128'(in_ack_o), 128'd2);

        // Outstanding limit: port0 fills to 4, port1 still served
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            applyResponse(1'b0, 1'b0, 16'h0, 128'h0);
            applyStimulus(2'b01, 16'h0, 16'h0, 16'h0003, 16'h0007, 1'b1);
            expectRequest(16'h0003);
            #1;
            checkOutput("fill accept0", 128'(in_accept_o), 128'd1);
            checkScoreboard();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            applyStimulus(2'b11, 16'h0, 16'h0, 16'h0003, 16'h0007, 1'b1);
            expectRequest(16'h8007);
            #1;
            checkOutput("limit port1 accept", 128'(in_accept_o), 128'd2);
            checkScoreboard();
        end
        @(negedge clk);
        applyStimulus(2'b01, 16'h0, 16'h0, 16'h0003, 16'h0007, 1'b1);
        applyResponse(1'b1, 1'b0, 16'h0003, 128'h0);
        #1;
        checkOutput("limit blocked", 128'(in_accept_o), 128'd0);
        checkOutput("limit ram_rd", 128'(ram_rd_o), 128'd0);
        checkOutput("limit ack", 128'(in_ack_o), 128'd1);
        @(negedge clk);
        applyResponse(1'b0, 1'b0, 16'h0, 128'h0);
        expectRequest(16'h0003);
        #1;
        checkOutput("limit reopened", 128'(in_accept_o), 128'd1);
        checkScoreboard();

        // Port1 at 3 outstanding: held, then accept and ack in the same cycle
        @(negedge clk);
        applyStimulus(2'b10, 16'h0, 16'h0, 16'h0, 16'h0005, 1'b1);
        expectRequest(16'h8005);
        #1;
        checkOutput("p1 third accept", 128'(in_accept_o), 128'd2);
        checkScoreboard();
        @(negedge clk);
        applyStimulus(2'b10, 16'h0, 16'h0, 16'h0, 16'h0005, 1'b0);
        #1;
        checkOutput("p1 stalled", 128'(in_accept_o), 128'd0);
        checkOutput("p1 stalled id", 128'(ram_req_id_o), 128'h8005);
        @(negedge clk);
        applyStimulus(2'b10, 16'h0, 16'h0, 16'h0, 16'h0005, 1'b1);
        applyResponse(1'b1, 1'b1, 16'h8005, 128'h77);
        expectRequest(16'h8005);
        #1;
        checkOutput("same accept", 128'(in_accept_o), 128'd2);
        checkOutput("same ack", 128'(in_ack_o), 128'd2);
        checkOutput("same resp_id", 128'(in_resp_id_o), 128'h0005);
        checkOutput("same error", 128'(in_error_o), 128'd1);
        checkScoreboard();
        @(negedge clk);
        applyResponse(1'b0, 1'b0, 16'h0, 128'h0);
        expectRequest(16'h8005);
        #1;
        checkOutput("p1 fourth accept", 128'(in_accept_o), 128'd2);
        checkScoreboard();
        @(negedge clk);
        #1;
        checkOutput("p1 at limit", 128'(in_accept_o), 128'd0);

        // Reset in the middle of a hold
        @(negedge clk);
        applyStimulus(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        applyResponse(1'b1, 1'b0, 16'h8005, 128'h0);
        #1;
        checkOutput("pre-reset ack", 128'(in_ack_o), 128'd2);
        @(negedge clk);
        applyResponse(1'b0, 1'b0, 16'h0, 128'h0);
        applyStimulus(2'b10, 16'h0, 16'h0, 16'h0, 16'h0009, 1'b0);
        #1;
        checkOutput("pre-reset hold rd", 128'(ram_rd_o), 128'd1);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(2'b10, 16'h0, 16'h0, 16'h0, 16'h0009, 1'b1);
        applyResponse(1'b1, 1'b0, 16'h8009, 128'h0);
        #1;
        checkOutput("mid-hold reset accept", 128'(in_accept_o), 128'd0);
        checkOutput("mid-hold reset ram_rd", 128'(ram_rd_o), 128'd0);
        checkOutput("mid-hold reset ack", 128'(in_ack_o), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b11, 16'h0, 16'h0, 16'h0011, 16'h0022, 1'b1);
        applyResponse(1'b0, 1'b0, 16'h0, 128'h0);
        expectRequest(16'h0011);
        #1;
        checkOutput("post-reset tie", 128'(in_accept_o), 128'd1);
        checkScoreboard();
        @(negedge clk);
        expectRequest(16'h8022);
        #1;
        checkOutput("post-reset port1", 128'(in_accept_o), 128'd2);
        checkScoreboard();

        @(negedge clk);
        applyStimulus(2'b00, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        checkOutput("sb empty", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
